// File: rtl/dct_arith_pkg.sv
// Shared arithmetic helpers for the DCT8 datapath (adder, butterfly, accumulator).
package dct_arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Bit patterns of the largest / smallest two's-complement value of width w.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(v)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_pipe_adder_if.sv
// Operand/result handshake bundle for seg_pipe_adder.
interface seg_pipe_adder_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_add_stage.sv
// One segment of the pipelined adder: SEG-bit add with registered sum, carry and valid.
module seg_add_stage #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_adv,
  input  logic           i_vld,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_c,
  input  logic           i_ovr,
  input  logic [SEG-1:0] i_ovr_val,
  output logic [SEG-1:0] o_raw,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_vld
);
  logic [SEG:0]   w_full;
  logic [SEG-1:0] r_sum;
  logic           r_cout;
  logic           r_vld;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_c};
  // Unregistered segment sum lets the top derive overflow in the final stage.
  assign o_raw  = w_full[SEG-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_vld  <= 1'b0;
    end else if (i_adv) begin
      r_sum  <= i_ovr ? i_ovr_val : w_full[SEG-1:0];
      r_cout <= w_full[SEG];
      r_vld  <= i_vld;
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_vld  = r_vld;
endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined segmented add/subtract with valid/ready and signed overflow.
// Define SEG_PIPE_ADDER_SAT_EN to saturate the result on signed overflow.
module seg_pipe_adder
  import dct_arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  seg_pipe_adder_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
`ifdef SEG_PIPE_ADDER_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] SAT_P = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SAT_N = WIDTH'(sat_min(WIDTH));

  logic                          w_adv;
  logic                          w_sub;
  logic                          w_c0;
  logic [STAGES-1:0][WIDTH-1:0]  w_a_in, w_b_in, r_a, r_b;
  logic [STAGES-1:0][WIDTH-1:0]  w_lo_nxt, r_lo;
  logic [STAGES-1:0][SEG-1:0]    w_seg_raw, w_seg_sum;
  logic [STAGES-1:0]             w_c_in, w_cout;
  logic [STAGES:0]               w_vld_pipe;
  logic                          w_a_msb, w_b_msb, w_ovf_nxt, w_ovr, r_ovf;
  logic [WIDTH-1:0]              w_sat_val;

  function automatic logic [WIDTH-1:0] put_seg(input logic [WIDTH-1:0] base,
                                               input logic [SEG-1:0]   seg,
                                               input int               idx);
    logic [WIDTH-1:0] r;
    r = base;
    r[idx*SEG +: SEG] = seg;
    return r;
  endfunction

  assign w_adv         = !w_vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = w_adv || rst;
  assign w_sub         = (bus.sub == OP_SUB);
  assign w_c0          = bus.cin ^ w_sub;
  assign w_vld_pipe[0] = bus.in_valid;

  // Stage k sees operands skewed by k registers; carry comes from stage k-1.
  always_comb begin
    w_a_in    = '0;
    w_b_in    = '0;
    w_c_in    = '0;
    w_a_in[0] = bus.a;
    w_b_in[0] = w_sub ? ~bus.b : bus.b;
    w_c_in[0] = w_c0;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_c_in[k] = w_cout[k-1];
    end
  end

  // Operand MSBs are in the last stage's segment, so overflow resolves there.
  assign w_a_msb   = w_a_in[STAGES-1][MSB];
  assign w_b_msb   = w_b_in[STAGES-1][MSB];
  assign w_ovf_nxt = (w_a_msb == w_b_msb) && (w_seg_raw[STAGES-1][SEG-1] != w_a_msb);
  assign w_ovr     = SAT_EN && w_ovf_nxt;
  assign w_sat_val = w_a_msb ? SAT_N : SAT_P;

  // Deskew: r_lo[k] carries the finished segments below k alongside stage k.
  always_comb begin
    w_lo_nxt = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_lo_nxt[k] = put_seg(r_lo[k-1], w_seg_sum[k-1], k - 1);
    end
    if (w_ovr) w_lo_nxt[STAGES-1] = w_sat_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_lo  <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_a   <= w_a_in;
      r_b   <= w_b_in;
      r_lo  <= w_lo_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    seg_add_stage #(.SEG(SEG)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .i_adv     (w_adv),
      .i_vld     (w_vld_pipe[k]),
      .i_a       (w_a_in[k][k*SEG +: SEG]),
      .i_b       (w_b_in[k][k*SEG +: SEG]),
      .i_c       (w_c_in[k]),
      .i_ovr     ((k == STAGES - 1) && w_ovr),
      .i_ovr_val (w_sat_val[k*SEG +: SEG]),
      .o_raw     (w_seg_raw[k]),
      .o_sum     (w_seg_sum[k]),
      .o_cout    (w_cout[k]),
      .o_vld     (w_vld_pipe[k+1])
    );
  end

  assign bus.out_valid = w_vld_pipe[STAGES];
  assign bus.sum       = put_seg(r_lo[STAGES-1], w_seg_sum[STAGES-1], STAGES - 1);
  assign bus.cout      = w_cout[STAGES-1];
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed + scoreboard bench for seg_pipe_adder (WIDTH=16, STAGES=2).
module tb_seg_pipe_adder;
  localparam int W = 16;
  localparam int S = 2;
`ifdef SEG_PIPE_ADDER_SAT_EN
  localparam logic [W-1:0] E_ADD_OVF = 16'h7FFF;
  localparam logic [W-1:0] E_SUB_OVF = 16'h8000;
  localparam logic [W-1:0] E_NEG_OVF = 16'h8000;
`else
  localparam logic [W-1:0] E_ADD_OVF = 16'h8000;
  localparam logic [W-1:0] E_SUB_OVF = 16'h7FFF;
  localparam logic [W-1:0] E_NEG_OVF = 16'h0000;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_pipe_adder_if #(.WIDTH(W)) bif ();
  seg_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bif));

  res_t q[$];
  res_t e, hv;
  logic held = 1'b0;
  int   checks = 0, failures = 0, n_pop = 0;

  // Reference: integer arithmetic straight from the add/subtract definition.
  function automatic res_t model(input logic [W-1:0] a, b, input logic cin, sub);
    res_t r;
    int sa, sb, v;
    logic [W:0] full;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      v    = sa - sb - int'(cin);
      full = (W+1)'((2 ** W) + int'(a) - int'(b) - int'(cin));
    end else begin
      v    = sa + sb + int'(cin);
      full = (W+1)'(int'(a) + int'(b) + int'(cin));
    end
    r.o = (v > (2 ** (W - 1)) - 1) || (v < -(2 ** (W - 1)));
    r.c = full[W];
    r.s = full[W-1:0];
`ifdef SEG_PIPE_ADDER_SAT_EN
    if (r.o) r.s = (v > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop/compare on delivery, check hold while stalled.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held = 1'b0;
    end else begin
      chk("in_ready_rule", 32'(bif.in_ready), 32'(!bif.out_valid || bif.out_ready));
      if (held) begin
        chk("hold_valid", 32'(bif.out_valid), 32'd1);
        chk("hold_sum", 32'(bif.sum), 32'(hv.s));
        chk("hold_flags", {30'd0, bif.cout, bif.ovf}, {30'd0, hv.c, hv.o});
      end
      if (bif.out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 32'(bif.out_valid), 32'd0);
        else if (bif.out_ready) begin
          e = q.pop_front();
          n_pop++;
          chk("sb_sum", 32'(bif.sum), 32'(e.s));
          chk("sb_cout", 32'(bif.cout), 32'(e.c));
          chk("sb_ovf", 32'(bif.ovf), 32'(e.o));
        end
        held = !bif.out_ready;
        hv.s = bif.sum;
        hv.c = bif.cout;
        hv.o = bif.ovf;
      end else begin
        held = 1'b0;
      end
      if (bif.in_valid && bif.in_ready) q.push_back(model(bif.a, bif.b, bif.cin, bif.sub));
    end
  end

  task automatic dir_op(input logic [W-1:0] a, b, input logic cin, sub,
                        input logic [W-1:0] es, input logic ec, eo, input string nm);
    int lat;
    @(posedge clk); #1;
    bif.a = a; bif.b = b; bif.cin = cin; bif.sub = sub;
    bif.in_valid = 1'b1; bif.out_ready = 1'b1;
    @(posedge clk); #1;
    bif.in_valid = 1'b0;
    lat = 1;
    while (!bif.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(S));
    chk({nm, "_sum"}, 32'(bif.sum), 32'(es));
    chk({nm, "_cout"}, 32'(bif.cout), 32'(ec));
    chk({nm, "_ovf"}, 32'(bif.ovf), 32'(eo));
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int i, cyc, stall, p0, acc, n;
    bif.in_valid = 1'b0; bif.a = '0; bif.b = '0; bif.cin = 1'b0; bif.sub = 1'b0;
    bif.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("rst_sum", 32'(bif.sum), 32'd0);
    chk("rst_flags", {30'd0, bif.cout, bif.ovf}, 32'd0);
    rst = 1'b0;

    // Hand-computed vectors pinning both the DUT and the model.
    dir_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "add_seg_carry");
    dir_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    dir_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, E_ADD_OVF, 1'b0, 1'b1, "add_pos_ovf");
    dir_op(16'h8000, 16'h8000, 1'b0, 1'b0, E_NEG_OVF, 1'b1, 1'b1, "add_neg_ovf");
    dir_op(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0, "add_cin");
    dir_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    dir_op(16'h8000, 16'h0001, 1'b0, 1'b1, E_SUB_OVF, 1'b1, 1'b1, "sub_ovf");
    dir_op(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0, "sub_bin");
    drain("drain_directed");

    // Eight back-to-back ops with a three-cycle downstream stall.
    p0 = n_pop; i = 0; cyc = 0; stall = 0;
    @(posedge clk); #1;
    while (i < 8 && cyc < 60) begin
      bif.out_ready = !(cyc >= 3 && cyc <= 5);
      bif.a = 16'(i * 16'h1111); bif.b = 16'(16'h7F0F + i); bif.cin = i[0]; bif.sub = i[1];
      bif.in_valid = 1'b1;
      @(negedge clk);
      acc = int'(bif.in_ready);
      if (!bif.in_ready) stall++;
      @(posedge clk); #1;
      if (acc != 0) i++;
      cyc++;
    end
    bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    drain("drain_stream");
    chk("stream_stall_cycles", 32'(stall), 32'd3);
    chk("stream_delivered", 32'(n_pop - p0), 32'd8);

    // Reset with two operations in flight.
    @(posedge clk); #1;
    bif.a = 16'h1111; bif.b = 16'h2222; bif.sub = 1'b0; bif.cin = 1'b0; bif.in_valid = 1'b1;
    @(posedge clk); #1;
    bif.a = 16'h3333; bif.b = 16'h0001; bif.out_ready = 1'b0;
    @(posedge clk); #1;
    bif.in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bif.out_ready = 1'b1;
    chk("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst_sum", 32'(bif.sum), 32'd0);
    chk("midrst_flags", {30'd0, bif.cout, bif.ovf}, 32'd0);
    chk("midrst_in_ready", 32'(bif.in_ready), 32'd1);
    repeat (5) @(posedge clk);

    // Random operands (biased to corner values) with random valid/ready.
    n = 0; cyc = 0;
    #1;
    while (n < 400 && cyc < 5000) begin
      @(negedge clk);
      acc = int'(bif.in_valid && bif.in_ready);
      if (acc != 0) n++;
      @(posedge clk); #1;
      cyc++;
      if (!bif.in_valid || acc != 0) begin
        case ($urandom_range(0, 4))
          0: bif.a = 16'h7FFF;
          1: bif.a = 16'h8000;
          2: bif.a = 16'hFFFF;
          default: bif.a = 16'($urandom);
        endcase
        bif.b = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
        bif.cin = 1'($urandom);
        bif.sub = 1'($urandom);
        bif.in_valid = ($urandom_range(0, 3) != 0);
      end
      bif.out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("random_accepted", 32'(n), 32'd400);
    bif.in_valid = 1'b0; bif.out_ready = 1'b1;
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
